// File: rtl/graphics_pkg.sv
// Shared constants and types for the display-buffer write path.
package graphics_pkg;

  localparam int PIXEL_ADDR_WIDTH = 18;
  localparam int PIXEL_DATA_WIDTH = 4;

  localparam int SPRITE  = 0;
  localparam int VECTOR  = 1;
  localparam int POLYGON = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } switch_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO holding queued pixel writes for one drawing engine.
module pixel_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Round-robin arbiter sharing the display-buffer write port between drawing
// engines, plus the show-request sequencer that switches buffers once drained.
//
//   state  | meaning
//   RUN    | normal drawing, no switch outstanding
//   DRAIN  | switch requested; waiting for engines idle, FIFOs empty, no write in flight
//   SWITCH | one-cycle buffer switch pulse to the display buffers
import graphics_pkg::*;

module pixel_write_arbiter #(
  parameter int REQUESTERS = 3,
  parameter int ADDR_WIDTH = PIXEL_ADDR_WIDTH,
  parameter int DATA_WIDTH = PIXEL_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clock_in,
  input  logic                             reset_n_in,
  input  logic [REQUESTERS-1:0]            req_valid_in,
  output logic [REQUESTERS-1:0]            req_ready_out,
  input  logic [REQUESTERS*ADDR_WIDTH-1:0] req_address_in,
  input  logic [REQUESTERS*DATA_WIDTH-1:0] req_data_in,
  input  logic [REQUESTERS-1:0]            engine_busy_in,
  input  logic                             switch_request_in,
  output logic                             switch_pending_out,
  output logic                             switch_write_buffer_out,
  output logic                             pixel_write_enable_out,
  output logic [ADDR_WIDTH-1:0]            pixel_write_address_out,
  output logic [DATA_WIDTH-1:0]            pixel_write_data_out,
  output logic [REQUESTERS-1:0]            grant_out
);

  localparam int PTR_W   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0]    w_head  [REQUESTERS];
  logic [CNT_W-1:0]      w_count [REQUESTERS];
  logic [REQUESTERS-1:0] w_full;
  logic [REQUESTERS-1:0] w_empty;
  logic [REQUESTERS-1:0] w_pop;
  logic                  w_pop_valid;
  logic [PTR_W-1:0]      w_pop_idx;
  logic [PTR_W-1:0]      w_rr_next;
  logic                  w_any_queued;
  logic                  w_drained;

  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_write_en;
  logic [ADDR_WIDTH-1:0] r_write_addr;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [REQUESTERS-1:0] r_grant;
  switch_state_t         r_state;
  logic                  r_pending;
  logic                  r_switch;

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_fifo
    pixel_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (clock_in),
      .i_rst_n (reset_n_in),
      .i_push  (req_valid_in[g] && req_ready_out[g]),
      .i_pop   (w_pop[g]),
      .i_data  ({req_address_in[g*ADDR_WIDTH +: ADDR_WIDTH],
                 req_data_in[g*DATA_WIDTH +: DATA_WIDTH]}),
      .o_data  (w_head[g]),
      .o_count (w_count[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );

    assign req_ready_out[g] = !w_full[g];
    assign w_pop[g]         = w_pop_valid && (w_pop_idx == PTR_W'(g));
  end

  // First non-empty FIFO at or after rr_ptr, wrapping once around the ring.
  always_comb begin
    int w_cand;
    w_pop_valid = 1'b0;
    w_pop_idx   = '0;
    w_cand      = 0;
    for (int k = 0; k < REQUESTERS; k++) begin
      w_cand = int'(r_rr_ptr) + k;
      if (w_cand >= REQUESTERS) w_cand = w_cand - REQUESTERS;
      if (!w_pop_valid && !w_empty[w_cand]) begin
        w_pop_valid = 1'b1;
        w_pop_idx   = PTR_W'(w_cand);
      end
    end
  end

  assign w_rr_next = (w_pop_idx == PTR_W'(REQUESTERS - 1)) ? '0 : w_pop_idx + 1'b1;

  always_comb begin
    w_any_queued = 1'b0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_count[i] != '0) w_any_queued = 1'b1;
    end
  end

  assign w_drained = !(|engine_busy_in) && !w_any_queued && !r_write_en;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_rr_ptr     <= '0;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_grant      <= '0;
    end else if (w_pop_valid) begin
      r_rr_ptr                     <= w_rr_next;
      r_write_en                   <= 1'b1;
      {r_write_addr, r_write_data} <= w_head[w_pop_idx];
      r_grant                      <= w_pop;
    end else begin
      r_write_en <= 1'b0;
      r_grant    <= '0;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state   <= RUN;
      r_pending <= 1'b0;
      r_switch  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_switch <= 1'b0;
          if (switch_request_in) begin
            r_state   <= DRAIN;
            r_pending <= 1'b1;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_state  <= SWITCH;
            r_switch <= 1'b1;
          end
        end
        SWITCH: begin
          r_switch <= 1'b0;
          // A request landing on the switch cycle starts a fresh drain rather than being lost.
          if (switch_request_in) begin
            r_state <= DRAIN;
          end else begin
            r_state   <= RUN;
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state   <= RUN;
          r_pending <= 1'b0;
          r_switch  <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_write_enable_out  = r_write_en;
  assign pixel_write_address_out = r_write_addr;
  assign pixel_write_data_out    = r_write_data;
  assign grant_out               = r_grant;
  assign switch_pending_out      = r_pending;
  assign switch_write_buffer_out = r_switch;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Directed bench for pixel_write_arbiter with an in-order per-requester scoreboard.
module tb_pixel_write_arbiter;

  localparam int R  = 3;
  localparam int AW = 18;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [R-1:0]    valid;
  logic [R-1:0]    ready;
  logic [R*AW-1:0] addr_flat;
  logic [R*DW-1:0] data_flat;
  logic [R-1:0]    busy;
  logic            sw_req;
  logic            pending;
  logic            sw_out;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [R-1:0]    grant;

  logic [AW-1:0]   base [R];
  logic [AW-1:0]   seq  [R];
  logic [DW-1:0]   dat  [R];

  logic [AW+DW-1:0] q [R][$];
  int acc [R];
  int wr  [R];
  int n_sw;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pixel_write_arbiter #(
    .REQUESTERS (R),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clock_in                (clk),
    .reset_n_in              (rst_n),
    .req_valid_in            (valid),
    .req_ready_out           (ready),
    .req_address_in          (addr_flat),
    .req_data_in             (data_flat),
    .engine_busy_in          (busy),
    .switch_request_in       (sw_req),
    .switch_pending_out      (pending),
    .switch_write_buffer_out (sw_out),
    .pixel_write_enable_out  (we),
    .pixel_write_address_out (waddr),
    .pixel_write_data_out    (wdata),
    .grant_out               (grant)
  );

  always_comb begin
    addr_flat = '0;
    data_flat = '0;
    for (int i = 0; i < R; i++) begin
      addr_flat[i*AW +: AW] = base[i] + seq[i];
      data_flat[i*DW +: DW] = dat[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Each address advances by one on every accepted handshake for that requester.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < R; i++) begin
        q[i].delete();
        seq[i] <= '0;
        acc[i] = 0;
        wr[i]  = 0;
      end
      n_sw = 0;
    end else begin
      if (we) begin
        check_eq("grant_onehot", $countones(grant), 1);
        for (int i = 0; i < R; i++) begin
          if (grant[i]) begin
            if (q[i].size() == 0) begin
              check_eq("write_unexpected", 32'(i), 32'hFFFF);
            end else begin
              check_eq("write_addr_data", 32'({waddr, wdata}), 32'(q[i].pop_front()));
              wr[i]++;
            end
          end
        end
      end
      if (sw_out) begin
        n_sw++;
        check_eq("switch_vs_write", 32'(we), 0);
      end
      for (int i = 0; i < R; i++) begin
        if (valid[i] && ready[i]) begin
          q[i].push_back({addr_flat[i*AW +: AW], data_flat[i*DW +: DW]});
          seq[i] <= seq[i] + 1'b1;
          acc[i]++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n  = 1'b0;
    valid  = '0;
    busy   = '0;
    sw_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n  = 1'b0;
    valid  = '0;
    busy   = '0;
    sw_req = 1'b0;
    for (int i = 0; i < R; i++) begin
      base[i] = '0;
      dat[i]  = '0;
    end

    // Reset values
    #12;
    check_eq("rst_ready", 32'(ready), 32'h7);
    check_eq("rst_we", 32'(we), 0);
    check_eq("rst_grant", 32'(grant), 0);
    check_eq("rst_addr", 32'(waddr), 0);
    check_eq("rst_data", 32'(wdata), 0);
    check_eq("rst_pending", 32'(pending), 0);
    check_eq("rst_switch", 32'(sw_out), 0);

    // Requester 0 alone: three writes, first visible two cycles after the first push
    do_reset;
    base[0] = 18'h00010;
    dat[0]  = 4'd5;
    valid   = 3'b001;
    tick;
    check_eq("t1_not_yet", 32'(we), 0);
    tick;
    check_eq("t1_w0_en", 32'(we), 1);
    check_eq("t1_w0_addr", 32'(waddr), 32'h10);
    check_eq("t1_w0_data", 32'(wdata), 5);
    check_eq("t1_w0_grant", 32'(grant), 1);
    tick;
    check_eq("t1_w1_en", 32'(we), 1);
    check_eq("t1_w1_addr", 32'(waddr), 32'h11);
    valid = '0;
    tick;
    check_eq("t1_w2_addr", 32'(waddr), 32'h12);
    check_eq("t1_w2_grant", 32'(grant), 1);
    tick;
    check_eq("t1_idle_en", 32'(we), 0);
    check_eq("t1_idle_grant", 32'(grant), 0);
    check_eq("t1_hold_addr", 32'(waddr), 32'h12);
    check_eq("t1_count", 32'(wr[0]), 3);

    // All three saturated: strict 001, 010, 100 rotation with no bubbles
    do_reset;
    for (int i = 0; i < R; i++) begin
      base[i] = 18'(i << 12);
      dat[i]  = 4'(i + 1);
    end
    valid = 3'b111;
    tick;
    for (int k = 0; k < 12; k++) begin
      tick;
      check_eq("t2_we", 32'(we), 1);
      check_eq("t2_grant", 32'(grant), 32'(1 << (k % 3)));
      if (k == 10) valid = '0;
    end
    repeat (30) tick;
    for (int i = 0; i < R; i++) check_eq("t2_acc_vs_wr", 32'(wr[i]), 32'(acc[i]));

    // Requester 1 backs up while 0 and 2 stay saturated
    do_reset;
    base[0] = 18'h00100;
    base[1] = 18'h00200;
    base[2] = 18'h00300;
    valid   = 3'b111;
    repeat (4) tick;
    check_eq("t3_ready_cnt3", 32'(ready[1]), 1);
    tick;
    check_eq("t3_ready_full", 32'(ready[1]), 0);
    guard = 0;
    while (acc[1] < 8 && guard < 100) begin
      tick;
      guard++;
    end
    valid[1] = 1'b0;
    check_eq("t3_acc1", 32'(acc[1]), 8);
    repeat (6) tick;
    valid = '0;
    repeat (40) tick;
    check_eq("t3_wr1", 32'(wr[1]), 8);
    for (int i = 0; i < R; i++) check_eq("t3_acc_vs_wr", 32'(wr[i]), 32'(acc[i]));

    // Switch held off by a busy polygon engine and three queued pixels
    do_reset;
    base[2] = 18'h03000;
    dat[2]  = 4'd9;
    busy    = 3'b100;
    valid   = 3'b100;
    tick;
    tick;
    sw_req = 1'b1;
    tick;
    sw_req = 1'b0;
    valid  = '0;
    check_eq("t4_pending", 32'(pending), 1);
    for (int k = 0; k < 5; k++) begin
      tick;
      check_eq("t4_no_switch", 32'(sw_out), 0);
      check_eq("t4_still_pending", 32'(pending), 1);
    end
    check_eq("t4_writes_done", 32'(wr[2]), 3);
    busy = '0;
    tick;
    check_eq("t4_switch", 32'(sw_out), 1);
    check_eq("t4_switch_pending", 32'(pending), 1);
    tick;
    check_eq("t4_switch_end", 32'(sw_out), 0);
    check_eq("t4_pending_end", 32'(pending), 0);
    check_eq("t4_one_pulse", 32'(n_sw), 1);

    // Coalesced requests in DRAIN, then a request on the SWITCH cycle
    do_reset;
    busy   = 3'b001;
    sw_req = 1'b1;
    tick;
    sw_req = 1'b0;
    check_eq("t5_pending", 32'(pending), 1);
    tick;
    sw_req = 1'b1;
    tick;
    sw_req = 1'b0;
    tick;
    sw_req = 1'b1;
    tick;
    sw_req = 1'b0;
    tick;
    check_eq("t5_no_switch", 32'(n_sw), 0);
    busy = '0;
    tick;
    check_eq("t5_switch", 32'(sw_out), 1);
    tick;
    check_eq("t5_switch_end", 32'(sw_out), 0);
    check_eq("t5_back_run", 32'(pending), 0);
    check_eq("t5_coalesced", 32'(n_sw), 1);
    sw_req = 1'b1;
    tick;
    sw_req = 1'b0;
    check_eq("t5b_drain", 32'(pending), 1);
    check_eq("t5b_drain_sw", 32'(sw_out), 0);
    tick;
    check_eq("t5b_switch1", 32'(sw_out), 1);
    sw_req = 1'b1;
    tick;
    sw_req = 1'b0;
    check_eq("t5b_redrain_sw", 32'(sw_out), 0);
    check_eq("t5b_redrain_pend", 32'(pending), 1);
    tick;
    check_eq("t5b_switch2", 32'(sw_out), 1);
    tick;
    check_eq("t5b_end", 32'(pending), 0);
    check_eq("t5b_pulses", 32'(n_sw), 3);

    // Asynchronous reset mid-cycle with pixels queued and a switch draining
    do_reset;
    base[0] = 18'h00400;
    base[1] = 18'h00500;
    base[2] = 18'h00600;
    busy    = 3'b010;
    valid   = 3'b111;
    sw_req  = 1'b1;
    tick;
    sw_req = 1'b0;
    tick;
    tick;
    check_eq("t6_pre_pending", 32'(pending), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("t6_we", 32'(we), 0);
    check_eq("t6_grant", 32'(grant), 0);
    check_eq("t6_addr", 32'(waddr), 0);
    check_eq("t6_pending", 32'(pending), 0);
    check_eq("t6_switch", 32'(sw_out), 0);
    check_eq("t6_ready", 32'(ready), 32'h7);
    valid = '0;
    busy  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) tick;
    check_eq("t6_no_stale", 32'(wr[0] + wr[1] + wr[2]), 0);
    check_eq("t6_post_pending", 32'(pending), 0);
    check_eq("t6_post_ready", 32'(ready), 32'h7);
    base[0] = 18'h00055;
    dat[0]  = 4'd3;
    valid   = 3'b001;
    tick;
    valid = '0;
    tick;
    check_eq("t6_fresh_we", 32'(we), 1);
    check_eq("t6_fresh_addr", 32'(waddr), 32'h55);
    check_eq("t6_fresh_data", 32'(wdata), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
